// File: rtl/aukv_pkg.sv
// rtl/aukv_pkg.sv - shared constants and write-back source enum for the GPR write-back scheduler
package aukv_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LSU  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/aukv_gpr_wb_sched_if.sv
// rtl/aukv_gpr_wb_sched_if.sv - issue, kill, ALU/LSU result and regfile write-port bundle
interface aukv_gpr_wb_sched_if;
    import aukv_pkg::*;

    logic            i_iss_valid;
    logic [AW-1:0]   i_iss_rd;
    logic [AW-1:0]   i_iss_rs1;
    logic [AW-1:0]   i_iss_rs2;
    logic            i_iss_rs1_used;
    logic            i_iss_rs2_used;
    logic            o_iss_stall;

    logic            i_kill_valid;
    logic [AW-1:0]   i_kill_rd;

    logic            i_alu_valid;
    logic [AW-1:0]   i_alu_rd;
    logic [XLEN-1:0] i_alu_data;

    logic            i_lsu_valid;
    logic            o_lsu_ready;
    logic [AW-1:0]   i_lsu_rd;
    logic [XLEN-1:0] i_lsu_data;

    logic            o_rf_we;
    logic [AW-1:0]   o_rf_rd_addr;
    logic [XLEN-1:0] o_rf_rd_data;

    logic [NREG-1:0] o_busy;

    modport master (
        output i_iss_valid, i_iss_rd, i_iss_rs1, i_iss_rs2, i_iss_rs1_used, i_iss_rs2_used,
        input  o_iss_stall,
        output i_kill_valid, i_kill_rd,
        output i_alu_valid, i_alu_rd, i_alu_data,
        output i_lsu_valid, i_lsu_rd, i_lsu_data,
        input  o_lsu_ready,
        input  o_rf_we, o_rf_rd_addr, o_rf_rd_data,
        input  o_busy
    );

    modport slave (
        input  i_iss_valid, i_iss_rd, i_iss_rs1, i_iss_rs2, i_iss_rs1_used, i_iss_rs2_used,
        output o_iss_stall,
        input  i_kill_valid, i_kill_rd,
        input  i_alu_valid, i_alu_rd, i_alu_data,
        input  i_lsu_valid, i_lsu_rd, i_lsu_data,
        output o_lsu_ready,
        output o_rf_we, o_rf_rd_addr, o_rf_rd_data,
        output o_busy
    );

endinterface

// File: rtl/aukv_scoreboard.sv
// rtl/aukv_scoreboard.sv - busy bitmap of GPRs with a write in flight, plus RAW/WAW hazard stall
module aukv_scoreboard
    import aukv_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_iss_valid,
    input  logic [AW-1:0]   i_iss_rd,
    input  logic [AW-1:0]   i_iss_rs1,
    input  logic [AW-1:0]   i_iss_rs2,
    input  logic            i_iss_rs1_used,
    input  logic            i_iss_rs2_used,
    input  logic            i_kill_valid,
    input  logic [AW-1:0]   i_kill_rd,
    input  logic            i_wb_we,
    input  logic [AW-1:0]   i_wb_rd,
    output logic            o_iss_stall,
    output logic [NREG-1:0] o_busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            stall;
    logic            iss_set;

    always_comb begin
        stall = i_iss_valid &&
                ((i_iss_rs1_used && busy_q[i_iss_rs1]) ||
                 (i_iss_rs2_used && busy_q[i_iss_rs2]) ||
                 busy_q[i_iss_rd]);
        iss_set = i_iss_valid && !stall && (i_iss_rd != '0);
    end

    // Clears applied before the set so a same-cycle issue wins over a kill of that reg.
    always_comb begin
        busy_d = busy_q;
        if (i_wb_we) begin
            busy_d[i_wb_rd] = 1'b0;
        end
        if (i_kill_valid) begin
            busy_d[i_kill_rd] = 1'b0;
        end
        if (iss_set) begin
            busy_d[i_iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_iss_stall = stall;
    assign o_busy      = busy_q;

endmodule

// File: rtl/aukv_gpr_wb_sched.sv
// rtl/aukv_gpr_wb_sched.sv - regfile write-port arbiter (ALU priority, 1-entry LSU buffer) and scoreboard
module aukv_gpr_wb_sched
    import aukv_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rstn,
    aukv_gpr_wb_sched_if.slave   bus
);

    logic            alu_wr;
    logic            lsu_ready;
    logic            lsu_acc;
    wb_src_e         src;

    logic            buf_full_q, buf_full_d;
    logic [AW-1:0]   buf_rd_q,   buf_rd_d;
    logic [XLEN-1:0] buf_data_q, buf_data_d;

    logic            rf_we_q,    rf_we_d;
    logic [AW-1:0]   rf_addr_q,  rf_addr_d;
    logic [XLEN-1:0] rf_data_q,  rf_data_d;

    always_comb begin
        alu_wr    = bus.i_alu_valid && (bus.i_alu_rd != '0);
        lsu_ready = !buf_full_q || !alu_wr;
        lsu_acc   = bus.i_lsu_valid && lsu_ready && (bus.i_lsu_rd != '0);
    end

    always_comb begin
        src = WB_NONE;
        if (alu_wr) begin
            src = WB_ALU;
        end else if (buf_full_q) begin
            src = WB_LSU;
        end
    end

    // A drain and a new accept may coincide; the accept refills the entry just emptied.
    always_comb begin
        buf_full_d = buf_full_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        if (src == WB_LSU) begin
            buf_full_d = 1'b0;
        end
        if (lsu_acc) begin
            buf_full_d = 1'b1;
            buf_rd_d   = bus.i_lsu_rd;
            buf_data_d = bus.i_lsu_data;
        end
    end

    always_comb begin
        rf_we_d   = 1'b0;
        rf_addr_d = rf_addr_q;
        rf_data_d = rf_data_q;
        case (src)
            WB_ALU: begin
                rf_we_d   = 1'b1;
                rf_addr_d = bus.i_alu_rd;
                rf_data_d = bus.i_alu_data;
            end
            WB_LSU: begin
                rf_we_d   = 1'b1;
                rf_addr_d = buf_rd_q;
                rf_data_d = buf_data_q;
            end
            default: begin
                rf_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            buf_full_q <= 1'b0;
            buf_rd_q   <= '0;
            buf_data_q <= '0;
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            buf_full_q <= buf_full_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            rf_we_q    <= rf_we_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
        end
    end

    aukv_scoreboard u_scoreboard (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_iss_valid    (bus.i_iss_valid),
        .i_iss_rd       (bus.i_iss_rd),
        .i_iss_rs1      (bus.i_iss_rs1),
        .i_iss_rs2      (bus.i_iss_rs2),
        .i_iss_rs1_used (bus.i_iss_rs1_used),
        .i_iss_rs2_used (bus.i_iss_rs2_used),
        .i_kill_valid   (bus.i_kill_valid),
        .i_kill_rd      (bus.i_kill_rd),
        .i_wb_we        (rf_we_q),
        .i_wb_rd        (rf_addr_q),
        .o_iss_stall    (bus.o_iss_stall),
        .o_busy         (bus.o_busy)
    );

    assign bus.o_lsu_ready  = lsu_ready;
    assign bus.o_rf_we      = rf_we_q;
    assign bus.o_rf_rd_addr = rf_addr_q;
    assign bus.o_rf_rd_data = rf_data_q;

endmodule

// File: tb/tb_aukv_gpr_wb_sched.sv
// tb/tb_aukv_gpr_wb_sched.sv - directed-vector bench for the GPR write-back scheduler
module tb_aukv_gpr_wb_sched;
    import aukv_pkg::*;

    logic clk;
    logic rstn;
    int   n_vec;
    int   n_err;

    aukv_gpr_wb_sched_if bus_if ();

    aukv_gpr_wb_sched dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_if.i_iss_valid    = 1'b0;
        bus_if.i_iss_rd       = '0;
        bus_if.i_iss_rs1      = '0;
        bus_if.i_iss_rs2      = '0;
        bus_if.i_iss_rs1_used = 1'b0;
        bus_if.i_iss_rs2_used = 1'b0;
        bus_if.i_kill_valid   = 1'b0;
        bus_if.i_kill_rd      = '0;
        bus_if.i_alu_valid    = 1'b0;
        bus_if.i_alu_rd       = '0;
        bus_if.i_alu_data     = '0;
        bus_if.i_lsu_valid    = 1'b0;
        bus_if.i_lsu_rd       = '0;
        bus_if.i_lsu_data     = '0;
    endtask

    task automatic issue(input logic [AW-1:0] rd, input logic [AW-1:0] rs1, input logic rs1_used);
        bus_if.i_iss_valid    = 1'b1;
        bus_if.i_iss_rd       = rd;
        bus_if.i_iss_rs1      = rs1;
        bus_if.i_iss_rs1_used = rs1_used;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rstn  = 1'b0;
        idle();
        #2;
        check("rst_busy",  bus_if.o_busy, 32'h0);
        check("rst_we",    32'(bus_if.o_rf_we), 32'h0);
        check("rst_addr",  32'(bus_if.o_rf_rd_addr), 32'h0);
        check("rst_data",  bus_if.o_rf_rd_data, 32'h0);
        check("rst_ready", 32'(bus_if.o_lsu_ready), 32'h1);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // RAW stall on x5, released once the ALU write retires
        issue(5'd5, 5'd0, 1'b0);
        #1;
        check("raw_first_stall", 32'(bus_if.o_iss_stall), 32'h0);
        tick();
        check("raw_busy5", bus_if.o_busy, 32'h0000_0020);
        issue(5'd6, 5'd5, 1'b1);
        bus_if.i_alu_valid = 1'b1;
        bus_if.i_alu_rd    = 5'd5;
        bus_if.i_alu_data  = 32'hDEAD_BEEF;
        #1;
        check("raw_stall_n", 32'(bus_if.o_iss_stall), 32'h1);
        tick();
        bus_if.i_alu_valid = 1'b0;
        #1;
        check("raw_we_n1",   32'(bus_if.o_rf_we), 32'h1);
        check("raw_addr_n1", 32'(bus_if.o_rf_rd_addr), 32'h5);
        check("raw_data_n1", bus_if.o_rf_rd_data, 32'hDEAD_BEEF);
        check("raw_stall_n1", 32'(bus_if.o_iss_stall), 32'h1);
        tick();
        check("raw_stall_n2", 32'(bus_if.o_iss_stall), 32'h0);
        check("raw_we_n2",    32'(bus_if.o_rf_we), 32'h0);
        check("raw_addr_hold", 32'(bus_if.o_rf_rd_addr), 32'h5);
        tick();
        idle();
        check("raw_busy6", bus_if.o_busy, 32'h0000_0040);
        bus_if.i_kill_valid = 1'b1;
        bus_if.i_kill_rd    = 5'd6;
        tick();
        idle();
        check("raw_cleanup", bus_if.o_busy, 32'h0);

        // ALU/LSU collision: ALU first, load one cycle later
        bus_if.i_alu_valid = 1'b1;
        bus_if.i_alu_rd    = 5'd3;
        bus_if.i_alu_data  = 32'h11;
        bus_if.i_lsu_valid = 1'b1;
        bus_if.i_lsu_rd    = 5'd4;
        bus_if.i_lsu_data  = 32'h22;
        #1;
        check("col_ready", 32'(bus_if.o_lsu_ready), 32'h1);
        tick();
        idle();
        check("col_we1",   32'(bus_if.o_rf_we), 32'h1);
        check("col_addr1", 32'(bus_if.o_rf_rd_addr), 32'h3);
        check("col_data1", bus_if.o_rf_rd_data, 32'h11);
        tick();
        check("col_we2",   32'(bus_if.o_rf_we), 32'h1);
        check("col_addr2", 32'(bus_if.o_rf_rd_addr), 32'h4);
        check("col_data2", bus_if.o_rf_rd_data, 32'h22);
        tick();
        check("col_we3", 32'(bus_if.o_rf_we), 32'h0);

        // Back-pressure: ALU writes 4 cycles in a row, LSU valid throughout
        for (int i = 0; i < 4; i++) begin
            bus_if.i_alu_valid = 1'b1;
            bus_if.i_alu_rd    = 5'd8;
            bus_if.i_alu_data  = 32'h100 + 32'(i);
            bus_if.i_lsu_valid = 1'b1;
            bus_if.i_lsu_rd    = 5'd9;
            bus_if.i_lsu_data  = 32'h99;
            #1;
            check($sformatf("bp_ready%0d", i), 32'(bus_if.o_lsu_ready), (i == 0) ? 32'h1 : 32'h0);
            tick();
            check($sformatf("bp_we%0d", i),   32'(bus_if.o_rf_we), 32'h1);
            check($sformatf("bp_addr%0d", i), 32'(bus_if.o_rf_rd_addr), 32'h8);
            check($sformatf("bp_data%0d", i), bus_if.o_rf_rd_data, 32'h100 + 32'(i));
        end
        idle();
        #1;
        check("bp_ready_idle", 32'(bus_if.o_lsu_ready), 32'h1);
        tick();
        check("bp_ld_we",   32'(bus_if.o_rf_we), 32'h1);
        check("bp_ld_addr", 32'(bus_if.o_rf_rd_addr), 32'h9);
        check("bp_ld_data", bus_if.o_rf_rd_data, 32'h99);
        tick();
        check("bp_done_we", 32'(bus_if.o_rf_we), 32'h0);

        // Kill clears busy; same-cycle issue beats kill
        issue(5'd7, 5'd0, 1'b0);
        tick();
        idle();
        check("kill_set", bus_if.o_busy, 32'h0000_0080);
        bus_if.i_kill_valid = 1'b1;
        bus_if.i_kill_rd    = 5'd7;
        tick();
        idle();
        check("kill_clr", bus_if.o_busy, 32'h0);
        issue(5'd7, 5'd0, 1'b0);
        bus_if.i_kill_valid = 1'b1;
        bus_if.i_kill_rd    = 5'd7;
        tick();
        idle();
        check("kill_vs_issue", bus_if.o_busy, 32'h0000_0080);
        bus_if.i_kill_valid = 1'b1;
        bus_if.i_kill_rd    = 5'd7;
        tick();
        idle();
        check("kill_cleanup", bus_if.o_busy, 32'h0);

        // x0 from every source is a no-op
        issue(5'd0, 5'd0, 1'b0);
        bus_if.i_alu_valid = 1'b1;
        bus_if.i_alu_rd    = 5'd0;
        bus_if.i_alu_data  = 32'h55;
        bus_if.i_lsu_valid = 1'b1;
        bus_if.i_lsu_rd    = 5'd0;
        bus_if.i_lsu_data  = 32'h66;
        #1;
        check("x0_stall", 32'(bus_if.o_iss_stall), 32'h0);
        check("x0_ready", 32'(bus_if.o_lsu_ready), 32'h1);
        tick();
        idle();
        check("x0_busy", bus_if.o_busy, 32'h0);
        check("x0_we1",  32'(bus_if.o_rf_we), 32'h0);
        tick();
        check("x0_we2",   32'(bus_if.o_rf_we), 32'h0);
        check("x0_addr",  32'(bus_if.o_rf_rd_addr), 32'h9);
        check("x0_data",  bus_if.o_rf_rd_data, 32'h99);

        // Reset mid-operation: busy=0x6, buffer held full behind the ALU
        issue(5'd1, 5'd0, 1'b0);
        tick();
        issue(5'd2, 5'd0, 1'b0);
        tick();
        idle();
        bus_if.i_alu_valid = 1'b1;
        bus_if.i_alu_rd    = 5'd10;
        bus_if.i_alu_data  = 32'h1;
        bus_if.i_lsu_valid = 1'b1;
        bus_if.i_lsu_rd    = 5'd11;
        bus_if.i_lsu_data  = 32'h2;
        tick();
        #1;
        check("mr_busy_pre",  bus_if.o_busy, 32'h0000_0006);
        check("mr_ready_pre", 32'(bus_if.o_lsu_ready), 32'h0);
        check("mr_we_pre",    32'(bus_if.o_rf_we), 32'h1);
        rstn = 1'b0;
        #1;
        check("mr_busy",  bus_if.o_busy, 32'h0);
        check("mr_we",    32'(bus_if.o_rf_we), 32'h0);
        check("mr_ready", 32'(bus_if.o_lsu_ready), 32'h1);
        check("mr_addr",  32'(bus_if.o_rf_rd_addr), 32'h0);
        idle();
        @(negedge clk);
        rstn = 1'b1;
        tick();
        tick();
        check("mr_no_drain", 32'(bus_if.o_rf_we), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
